// File: rtl/bist_pkg.sv
// Shared types and March element tables for the SRAM BIST controller.
// Each element is a direction plus up to two ops, each with a read flag and a background bit.
package bist_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] FLUSH = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   typedef enum logic {
      ALG_MATS   = 1'b0,
      ALG_MARCHC = 1'b1
   } alg_e;

   // rd[i]/bg[i] describe op i of the element; bg is the write value or the expected read value
   typedef struct packed {
      logic       down;
      logic [1:0] nops;
      logic [1:0] rd;
      logic [1:0] bg;
   } elem_t;

   localparam elem_t ELEM_PAD = '0;

   localparam elem_t MATS_TBL [0:7] = '{
      '{1'b0, 2'd1, 2'b00, 2'b00},
      '{1'b0, 2'd2, 2'b01, 2'b10},
      '{1'b1, 2'd2, 2'b01, 2'b01},
      ELEM_PAD, ELEM_PAD, ELEM_PAD, ELEM_PAD, ELEM_PAD
   };

   localparam elem_t MARCHC_TBL [0:7] = '{
      '{1'b0, 2'd1, 2'b00, 2'b00},
      '{1'b0, 2'd2, 2'b01, 2'b10},
      '{1'b0, 2'd2, 2'b01, 2'b01},
      '{1'b1, 2'd2, 2'b01, 2'b10},
      '{1'b1, 2'd2, 2'b01, 2'b01},
      '{1'b0, 2'd1, 2'b01, 2'b00},
      ELEM_PAD, ELEM_PAD
   };

   function automatic elem_t elem_lookup(input alg_e alg, input logic [2:0] idx);
      if (alg == ALG_MARCHC) return MARCHC_TBL[idx];
      return MATS_TBL[idx];
   endfunction

   function automatic logic [2:0] elem_count(input alg_e alg);
      return (alg == ALG_MARCHC) ? 3'd6 : 3'd3;
   endfunction

endpackage

// File: rtl/sram_sp.sv
// Behavioural single-port SRAM, synchronous write and one-cycle registered read.
// The injection hook forces bit 0 of read data high at one address; tie inj_en low on silicon.
module sram_sp #(
   parameter int size   = 6,
   parameter int length = 8
) (
   input  logic              clk,
   input  logic              ce,
   input  logic              we,
   input  logic [size-1:0]   addr,
   input  logic [length-1:0] wdata,
   input  logic              inj_en,
   input  logic [size-1:0]   inj_addr,
   output logic [length-1:0] rdata
);

   logic [length-1:0] mem [0:(1<<size)-1];
   logic              inj_hit;

   assign inj_hit = inj_en && (addr == inj_addr);

   always_ff @(posedge clk) begin
      if (ce) begin
         if (we) mem[addr] <= wdata;
         else    rdata     <= mem[addr] | {{(length-1){1'b0}}, inj_hit};
      end
   end

endmodule

// File: rtl/bist_march.sv
// SRAM wrapper with a normal access path and a MATS+/March C- self-test controller.
// Reports first-failure diagnostics and a saturating mismatch count.
module bist_march
   import bist_pkg::*;
#(
   parameter int size   = 6,
   parameter int length = 8,
   parameter int cntw   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              alg,
   input  logic              stop_on_fail,
   input  logic              inject,
   input  logic [size-1:0]   inj_addr,
   input  logic              csin,
   input  logic              rwbarin,
   input  logic [size-1:0]   address,
   input  logic [length-1:0] datain,
   output logic [length-1:0] dataout,
   output logic              busy,
   output logic              done,
   output logic              fail,
   output logic [size-1:0]   fail_addr,
   output logic [length-1:0] fail_exp,
   output logic [length-1:0] fail_act,
   output logic [cntw-1:0]   fail_count
);

   logic [1:0]        state;
   alg_e              alg_q;
   logic              stop_q, inj_q, halt, flush2, normal_rd;
   logic [size-1:0]   inj_addr_q, addr_cnt, cmp_addr;
   logic [2:0]        elem_idx;
   logic              op_sel, cmp_valid;
   logic [length-1:0] cmp_exp, rdata;

   elem_t             cur;
   logic              op_rd, op_bg, last_op_in_elem, last_addr, last_elem;
   logic              launch, idle_like, mismatch;
   logic [size-1:0]   op_addr;
   logic [length-1:0] op_data;

   logic              ram_ce, ram_we;
   logic [size-1:0]   ram_addr;
   logic [length-1:0] ram_wdata;

   assign idle_like       = (state == IDLE) || (state == DONE);
   assign launch          = start && idle_like;
   assign busy            = (state == RUN) || (state == FLUSH);
   assign done            = (state == DONE);

   assign cur             = elem_lookup(alg_q, elem_idx);
   assign op_rd           = cur.rd[op_sel];
   assign op_bg           = cur.bg[op_sel];
   assign op_addr         = cur.down ? ~addr_cnt : addr_cnt;
   assign op_data         = {length{op_bg}};
   assign last_op_in_elem = (cur.nops == 2'd1) || op_sel;
   assign last_addr       = &addr_cnt;
   assign last_elem       = (elem_idx == elem_count(alg_q) - 3'd1);

   // Once a stop-on-fail run has tripped, reads still in flight are never compared
   assign mismatch        = busy && cmp_valid && !halt && (rdata != cmp_exp);

   assign dataout         = normal_rd ? rdata : '0;

   // BIST owns the RAM while running; a start request suppresses the normal access
   always_comb begin
      ram_ce    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = address;
      ram_wdata = datain;
      if (state == RUN) begin
         ram_ce    = 1'b1;
         ram_we    = !op_rd;
         ram_addr  = op_addr;
         ram_wdata = op_data;
      end else if (idle_like && !start) begin
         ram_ce    = csin;
         ram_we    = !rwbarin;
      end
   end

   sram_sp #(.size(size), .length(length)) u_ram (
      .clk      (clk),
      .ce       (ram_ce),
      .we       (ram_we),
      .addr     (ram_addr),
      .wdata    (ram_wdata),
      .inj_en   (inj_q && busy),
      .inj_addr (inj_addr_q),
      .rdata    (rdata)
   );

   // FLUSH normally lasts two cycles so the final read is compared before DONE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         alg_q      <= ALG_MATS;
         stop_q     <= 1'b0;
         inj_q      <= 1'b0;
         inj_addr_q <= '0;
         elem_idx   <= '0;
         addr_cnt   <= '0;
         op_sel     <= 1'b0;
         halt       <= 1'b0;
         flush2     <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state      <= RUN;
                  alg_q      <= alg_e'(alg);
                  stop_q     <= stop_on_fail;
                  inj_q      <= inject;
                  inj_addr_q <= inj_addr;
                  elem_idx   <= '0;
                  addr_cnt   <= '0;
                  op_sel     <= 1'b0;
                  halt       <= 1'b0;
                  flush2     <= 1'b0;
               end
            end
            RUN: begin
               if (last_op_in_elem) begin
                  op_sel <= 1'b0;
                  if (last_addr) begin
                     addr_cnt <= '0;
                     if (last_elem) begin
                        state  <= FLUSH;
                        flush2 <= 1'b0;
                     end else begin
                        elem_idx <= elem_idx + 3'd1;
                     end
                  end else begin
                     addr_cnt <= addr_cnt + 1'b1;
                  end
               end else begin
                  op_sel <= 1'b1;
               end
            end
            default: begin
               if (flush2) state  <= DONE;
               else        flush2 <= 1'b1;
            end
         endcase
         if (mismatch && stop_q) begin
            state  <= FLUSH;
            flush2 <= 1'b1;
            halt   <= 1'b1;
         end
      end
   end

   // Read-compare pipeline plus first-failure capture and saturating count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmp_valid  <= 1'b0;
         cmp_exp    <= '0;
         cmp_addr   <= '0;
         normal_rd  <= 1'b0;
         fail       <= 1'b0;
         fail_addr  <= '0;
         fail_exp   <= '0;
         fail_act   <= '0;
         fail_count <= '0;
      end else begin
         cmp_valid <= (state == RUN) && op_rd;
         cmp_exp   <= op_data;
         cmp_addr  <= op_addr;
         if (launch || busy)        normal_rd <= 1'b0;
         else if (csin && rwbarin)  normal_rd <= 1'b1;
         else if (!csin)            normal_rd <= 1'b0;
         if (launch) begin
            fail       <= 1'b0;
            fail_addr  <= '0;
            fail_exp   <= '0;
            fail_act   <= '0;
            fail_count <= '0;
         end else if (mismatch) begin
            if (!fail) begin
               fail_addr <= cmp_addr;
               fail_exp  <= cmp_exp;
               fail_act  <= rdata;
            end
            fail <= 1'b1;
            if (fail_count != {cntw{1'b1}}) fail_count <= fail_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bist_march.sv
// Self-checking bench for bist_march: directed scenarios plus randomized runs
// checked against a March-notation reference model with its own memory image.
module tb_bist_march;

   localparam int N = 64;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0, alg = 1'b0, stop_on_fail = 1'b0, inject = 1'b0;
   logic [5:0] inj_addr = '0, address = '0;
   logic       csin = 1'b0, rwbarin = 1'b1;
   logic [7:0] datain = '0, dataout, fail_exp, fail_act, fail_count;
   logic       busy, done, fail;
   logic [5:0] fail_addr;

   int total = 0;
   int bad = 0;
   int mdl_mem [N];
   bit mem_known = 0;

   always #5 clk = ~clk;

   bist_march #(.size(6), .length(8), .cntw(8)) dut (
      .clk(clk), .rst(rst), .start(start), .alg(alg), .stop_on_fail(stop_on_fail),
      .inject(inject), .inj_addr(inj_addr), .csin(csin), .rwbarin(rwbarin),
      .address(address), .datain(datain), .dataout(dataout), .busy(busy), .done(done),
      .fail(fail), .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_act(fail_act),
      .fail_count(fail_count)
   );

   // Walks the algorithm in March notation; returns done latency and diagnostics
   function automatic void model_run(input bit a, input bit inj, input int ia, input bit stp,
                                     output int done_at, output int cnt, output int faddr,
                                     output int fexp, output int fact);
      string elems [$];
      string s;
      int k, stop_k, addr, val, got;
      if (a) elems = '{"*w0", "^r0w1", "^r1w0", "vr0w1", "vr1w0", "*r0"};
      else   elems = '{"*w0", "^r0w1", "vr1w0"};
      k = 0; stop_k = -1; cnt = 0; faddr = 0; fexp = 0; fact = 0;
      foreach (elems[e]) begin
         s = elems[e];
         for (int i = 0; i < N; i++) begin
            addr = (s.getc(0) == "v") ? N - 1 - i : i;
            for (int p = 1; p < s.len(); p += 2) begin
               val = (s.getc(p + 1) == "1") ? 255 : 0;
               if (stop_k < 0 || k <= stop_k + 1) begin
                  if (s.getc(p) == "w") mdl_mem[addr] = val;
                  else if (stop_k < 0) begin
                     got = mdl_mem[addr] | ((inj && addr == ia) ? 1 : 0);
                     if (got != val) begin
                        if (cnt == 0) begin faddr = addr; fexp = val; fact = got; end
                        cnt++;
                        if (stp) stop_k = k;
                     end
                  end
               end
               k++;
            end
         end
      end
      if (cnt > 255) cnt = 255;
      done_at = (stop_k >= 0) ? stop_k + 3 : k + 2;
      mem_known = (stop_k < 0);
   endfunction

   task automatic nwrite(input int a, input int d);
      @(negedge clk); csin = 1'b1; rwbarin = 1'b0; address = a[5:0]; datain = d[7:0];
      @(negedge clk); csin = 1'b0; rwbarin = 1'b1;
      mdl_mem[a] = d;
   endtask

   task automatic nread(input int a, output int d);
      @(negedge clk); csin = 1'b1; rwbarin = 1'b1; address = a[5:0];
      @(posedge clk); #1; d = int'(dataout);
      @(negedge clk); csin = 1'b0;
   endtask

   // Launches a run; n is the number of edges after E0 until done, bounded
   task automatic run_bist(input bit a, input bit s, input bit i, input int ia, input bit poke,
                           output int n, output bit busy0, output bit dout_bad);
      @(negedge clk);
      alg = a; stop_on_fail = s; inject = i; inj_addr = ia[5:0]; start = 1'b1;
      @(posedge clk); #1;
      busy0 = busy; start = 1'b0; n = 0; dout_bad = 1'b0;
      while (!done && n < 2000) begin
         @(posedge clk); #1;
         n++;
         if (busy && dataout !== 8'h00) dout_bad = 1'b1;
         start = poke && busy && (n % 37 == 5) && (n < 250);
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
      total++; if ({fail, fail_addr, fail_exp, fail_act, fail_count} !== '0)
         begin bad++; $display("[TB] FAIL reset_diag: got %h expected 0", {fail, fail_addr, fail_exp, fail_act, fail_count}); end
      total++; if (dataout !== 8'h00) begin bad++; $display("[TB] FAIL reset_dataout: got %h expected 00", dataout); end
      rst = 1'b0;
   endtask

   task automatic test_normal();
      int d;
      nwrite(10, 8'h3C);
      nread(10, d);
      total++; if (d !== 32'h3C) begin bad++; $display("[TB] FAIL normal_read: got %h expected 3c", d); end
      @(posedge clk); #1;
      total++; if (dataout !== 8'h00) begin bad++; $display("[TB] FAIL normal_csin0: got %h expected 00", dataout); end
   endtask

   task automatic test_mats_clean();
      int n, dn, c, fa, fe, fc; bit b0, db;
      model_run(1'b0, 1'b0, 0, 1'b0, dn, c, fa, fe, fc);
      run_bist(1'b0, 1'b0, 1'b0, 0, 1'b0, n, b0, db);
      total++; if (b0 !== 1'b1) begin bad++; $display("[TB] FAIL mats_busy_e0: got %b expected 1", b0); end
      total++; if (n != 322) begin bad++; $display("[TB] FAIL mats_cycles: got %0d expected 322", n); end
      total++; if ({fail, fail_count} !== 9'd0) begin bad++; $display("[TB] FAIL mats_pass: got fail=%b cnt=%0d expected 0/0", fail, fail_count); end
      total++; if (db !== 1'b0) begin bad++; $display("[TB] FAIL mats_dataout_busy: got nonzero expected 00"); end
   endtask

   task automatic test_marchc_clean();
      int n, dn, c, fa, fe, fc, d; bit b0, db;
      model_run(1'b1, 1'b0, 0, 1'b0, dn, c, fa, fe, fc);
      run_bist(1'b1, 1'b0, 1'b0, 0, 1'b0, n, b0, db);
      total++; if (n != 642) begin bad++; $display("[TB] FAIL marchc_cycles: got %0d expected 642", n); end
      total++; if (fail !== 1'b0) begin bad++; $display("[TB] FAIL marchc_pass: got %b expected 0", fail); end
      nread(7, d);
      total++; if (d !== 0) begin bad++; $display("[TB] FAIL marchc_readback: got %h expected 00", d); end
   endtask

   task automatic test_marchc_fault();
      int n, dn, c, fa, fe, fc; bit b0, db;
      model_run(1'b1, 1'b1, 5, 1'b0, dn, c, fa, fe, fc);
      run_bist(1'b1, 1'b0, 1'b1, 5, 1'b0, n, b0, db);
      total++; if (n != 642) begin bad++; $display("[TB] FAIL fault_cycles: got %0d expected 642", n); end
      total++; if ({fail, fail_addr, fail_exp, fail_act} !== {1'b1, 6'd5, 8'h00, 8'h01})
         begin bad++; $display("[TB] FAIL fault_capture: got fail=%b addr=%0d exp=%h act=%h expected 1/5/00/01", fail, fail_addr, fail_exp, fail_act); end
      total++; if (fail_count !== 8'd3) begin bad++; $display("[TB] FAIL fault_count: got %0d expected 3", fail_count); end
   endtask

   task automatic test_stop_on_fail();
      int n, dn, c, fa, fe, fc; bit b0, db;
      model_run(1'b0, 1'b1, 0, 1'b1, dn, c, fa, fe, fc);
      run_bist(1'b0, 1'b1, 1'b1, 0, 1'b0, n, b0, db);
      total++; if (n != 67) begin bad++; $display("[TB] FAIL stop_cycles: got %0d expected 67", n); end
      total++; if ({fail, fail_addr, fail_count} !== {1'b1, 6'd0, 8'd1})
         begin bad++; $display("[TB] FAIL stop_capture: got fail=%b addr=%0d cnt=%0d expected 1/0/1", fail, fail_addr, fail_count); end
   endtask

   task automatic test_reset_midrun();
      int n, dn, c, fa, fe, fc; bit b0, db;
      @(negedge clk);
      alg = 1'b1; stop_on_fail = 1'b0; inject = 1'b1; inj_addr = 6'd5; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      total++; if ({busy, fail} !== 2'b11) begin bad++; $display("[TB] FAIL midrun_state: got busy=%b fail=%b expected 1/1", busy, fail); end
      #2 rst = 1'b1;
      #1;
      total++; if ({busy, done, fail, fail_count} !== '0)
         begin bad++; $display("[TB] FAIL midrun_reset: got busy=%b done=%b fail=%b cnt=%0d expected 0", busy, done, fail, fail_count); end
      @(negedge clk); rst = 1'b0;
      model_run(1'b0, 1'b0, 0, 1'b0, dn, c, fa, fe, fc);
      run_bist(1'b0, 1'b0, 1'b0, 0, 1'b1, n, b0, db);
      total++; if (n != 322) begin bad++; $display("[TB] FAIL restart_cycles: got %0d expected 322", n); end
      total++; if ({done, fail} !== 2'b10) begin bad++; $display("[TB] FAIL restart_pass: got done=%b fail=%b expected 1/0", done, fail); end
   endtask

   task automatic test_random_runs();
      int n, dn, c, fa, fe, fc, ia, a, d, got; bit b0, db, ra, ri, rs;
      for (int it = 0; it < 6; it++) begin
         ra = 1'($urandom); ri = 1'($urandom); rs = 1'($urandom); ia = int'($urandom_range(0, N - 1));
         model_run(ra, ri, ia, rs, dn, c, fa, fe, fc);
         run_bist(ra, rs, ri, ia, 1'($urandom), n, b0, db);
         total++; if (n != dn) begin bad++; $display("[TB] FAIL rand_cycles[%0d]: got %0d expected %0d", it, n, dn); end
         total++; if (fail !== (c > 0) || int'(fail_count) != c)
            begin bad++; $display("[TB] FAIL rand_result[%0d]: got fail=%b cnt=%0d expected cnt=%0d", it, fail, fail_count, c); end
         if (c > 0) begin
            total++;
            if (int'(fail_addr) != fa || int'(fail_exp) != fe || int'(fail_act) != fc)
               begin bad++; $display("[TB] FAIL rand_capture[%0d]: got %0d/%h/%h expected %0d/%h/%h", it, fail_addr, fail_exp, fail_act, fa, fe, fc); end
         end
         if (mem_known) begin
            for (int j = 0; j < 3; j++) begin
               a = int'($urandom_range(0, N - 1));
               d = int'($urandom_range(0, 255));
               if ($urandom_range(0, 1) == 1) nwrite(a, d);
               nread(a, got);
               total++; if (got != mdl_mem[a]) begin bad++; $display("[TB] FAIL rand_mem[%0d]: addr=%0d got %h expected %h", it, a, got, mdl_mem[a]); end
            end
         end
      end
   endtask

   initial begin
      $display("[TB] starting bist_march bench");
      test_reset();
      test_normal();
      test_mats_clean();
      test_marchc_clean();
      test_marchc_fault();
      test_stop_on_fail();
      test_reset_midrun();
      test_random_runs();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
